// File: rtl/stt_fsm_prog_pkg.sv
// Shared constants and helpers for the programmable state-transition-table FSM.
package stt_pkg;

  localparam int STT_IN_W        = 4;
  localparam int STT_STATE_W     = 3;
  localparam int STT_OUT_W       = 8;
  localparam int STT_NUM_STATES  = 6;
  localparam int STT_RESET_STATE = 0;

  // What the control path does with the current cycle.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_RESTART,
    ACT_HIT,
    ACT_MISS,
    ACT_BAD
  } stt_act_e;

  // Table entry layout is {valid, next, out}.
  function automatic int stt_ent_w(input int state_w, input int out_w);
    return 1 + state_w + out_w;
  endfunction

  function automatic int unsigned stt_addr(input int unsigned s, input int unsigned i,
                                           input int unsigned in_w);
    return (s << in_w) | i;
  endfunction

endpackage

// File: rtl/stt_fsm_prog_if.sv
// Config, step and result signals of stt_fsm_prog grouped as one bus.
interface stt_fsm_prog_if
  import stt_pkg::*;
#(
  parameter int IN_W    = STT_IN_W,
  parameter int STATE_W = STT_STATE_W,
  parameter int OUT_W   = STT_OUT_W
);
  logic                     cfg_we;
  logic [STATE_W+IN_W-1:0]  cfg_addr;
  logic                     cfg_valid;
  logic [STATE_W-1:0]       cfg_next;
  logic [OUT_W-1:0]         cfg_out;
  logic                     restart;
  logic                     in_valid;
  logic [IN_W-1:0]          in;
  logic [OUT_W-1:0]         out;
  logic                     out_valid;
  logic [STATE_W-1:0]       state;
  logic                     miss;
  logic                     err;

  modport master (
    output cfg_we, cfg_addr, cfg_valid, cfg_next, cfg_out, restart, in_valid, in,
    input  out, out_valid, state, miss, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_valid, cfg_next, cfg_out, restart, in_valid, in,
    output out, out_valid, state, miss, err
  );
endinterface

// File: rtl/stt_fsm_prog_table.sv
// Transition table: legality-checked write port, async read that sees the pre-write entry.
module stt_table
  import stt_pkg::*;
#(
  parameter int IN_W       = STT_IN_W,
  parameter int STATE_W    = STT_STATE_W,
  parameter int OUT_W      = STT_OUT_W,
  parameter int NUM_STATES = STT_NUM_STATES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [STATE_W+IN_W-1:0] i_waddr,
  input  logic                    i_wvalid,
  input  logic [STATE_W-1:0]      i_wnext,
  input  logic [OUT_W-1:0]        i_wout,
  output logic                    o_werr,
  input  logic [STATE_W+IN_W-1:0] i_raddr,
  output logic                    o_rvalid,
  output logic [STATE_W-1:0]      o_rnext,
  output logic [OUT_W-1:0]        o_rout
);
  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ENT_W  = stt_ent_w(STATE_W, OUT_W);
  localparam logic [STATE_W:0] NS = (STATE_W+1)'(NUM_STATES);

  logic [DEPTH-1:0]   r_vld;
  logic [STATE_W-1:0] r_next [DEPTH];
  logic [OUT_W-1:0]   r_out  [DEPTH];

  logic [STATE_W-1:0] w_wstate;
  logic               w_bad;
  logic [ENT_W-1:0]   w_ent;

  assign w_wstate = i_waddr[ADDR_W-1 -: STATE_W];
  assign w_bad    = ({1'b0, w_wstate} >= NS) || (i_wvalid && ({1'b0, i_wnext} >= NS));
  assign o_werr   = i_we && w_bad;

  // Only the valid bits need clearing; stale fields are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_we && !w_bad) begin
      r_vld[i_waddr] <= i_wvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && i_we && !w_bad) begin
      r_next[i_waddr] <= i_wnext;
      r_out[i_waddr]  <= i_wout;
    end
  end

  assign w_ent    = {r_vld[i_raddr], r_next[i_raddr], r_out[i_raddr]};
  assign o_rvalid = w_ent[ENT_W-1];
  assign o_rnext  = w_ent[ENT_W-2 -: STATE_W];
  assign o_rout   = w_ent[OUT_W-1:0];
endmodule

// File: rtl/stt_fsm_prog.sv
// Table-driven Mealy FSM: state/out/miss/err registers with rst_n > restart > step priority.
module stt_fsm_prog
  import stt_pkg::*;
#(
  parameter int IN_W        = STT_IN_W,
  parameter int STATE_W     = STT_STATE_W,
  parameter int OUT_W       = STT_OUT_W,
  parameter int NUM_STATES  = STT_NUM_STATES,
  parameter int RESET_STATE = STT_RESET_STATE
) (
  input logic           clk,
  input logic           rst_n,
  stt_fsm_prog_if.slave bus
);
  localparam int ADDR_W = STATE_W + IN_W;
  localparam logic [STATE_W:0]   NS = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] RS = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] r_state, w_state_n;
  logic [OUT_W-1:0]   r_out, w_out_n;
  logic               r_ovld, w_ovld_n;
  logic               r_miss, w_miss_n;
  logic               r_err, w_err_n;

  logic [ADDR_W-1:0]  w_raddr;
  logic               w_rvalid;
  logic [STATE_W-1:0] w_rnext;
  logic [OUT_W-1:0]   w_rout;
  logic               w_cfg_err;
  stt_act_e           w_act;

  assign w_raddr = ADDR_W'(stt_addr(32'(r_state), 32'(bus.in), IN_W));

  stt_table #(
    .IN_W       (IN_W),
    .STATE_W    (STATE_W),
    .OUT_W      (OUT_W),
    .NUM_STATES (NUM_STATES)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (bus.cfg_we),
    .i_waddr  (bus.cfg_addr),
    .i_wvalid (bus.cfg_valid),
    .i_wnext  (bus.cfg_next),
    .i_wout   (bus.cfg_out),
    .o_werr   (w_cfg_err),
    .i_raddr  (w_raddr),
    .o_rvalid (w_rvalid),
    .o_rnext  (w_rnext),
    .o_rout   (w_rout)
  );

  always_comb begin
    w_act = ACT_IDLE;
    if (bus.restart)                      w_act = ACT_RESTART;
    else if (bus.in_valid) begin
      if ({1'b0, r_state} >= NS)          w_act = ACT_BAD;
      else if (w_rvalid)                  w_act = ACT_HIT;
      else                                w_act = ACT_MISS;
    end
  end

  // out and miss deliberately hold across idle cycles.
  always_comb begin
    w_state_n = r_state;
    w_out_n   = r_out;
    w_ovld_n  = 1'b0;
    w_miss_n  = r_miss;
    w_err_n   = r_err | w_cfg_err;
    unique case (w_act)
      ACT_RESTART: begin
        w_state_n = RS;
        w_out_n   = '0;
        w_miss_n  = 1'b0;
      end
      ACT_HIT: begin
        w_state_n = w_rnext;
        w_out_n   = w_rout;
        w_ovld_n  = 1'b1;
        w_miss_n  = 1'b0;
      end
      ACT_MISS: begin
        w_out_n   = '0;
        w_ovld_n  = 1'b1;
        w_miss_n  = 1'b1;
      end
      ACT_BAD: begin
        w_state_n = RS;
        w_out_n   = '0;
        w_ovld_n  = 1'b1;
        w_err_n   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RS;
      r_out   <= '0;
      r_ovld  <= 1'b0;
      r_miss  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_out   <= w_out_n;
      r_ovld  <= w_ovld_n;
      r_miss  <= w_miss_n;
      r_err   <= w_err_n;
    end
  end

  assign bus.state     = r_state;
  assign bus.out       = r_out;
  assign bus.out_valid = r_ovld;
  assign bus.miss      = r_miss;
  assign bus.err       = r_err;
endmodule

// File: doc/stt_fsm_prog.md
Name: stt_fsm_prog

Overview:
Table-driven Mealy state machine. Parametrised, run-time-programmable successor to our fixed generated state-transition-table FSMs. Transitions and outputs live in a loadable table indexed by {state, in}, so one instance runs any benchmark machine up to the configured size. Sits between the stimulus source and the output checker in the STT-to-Verilog flow. Adds an input-valid qualifier, miss detection for unspecified entries, and soft restart.

Parameters:
IN_W, 4, input symbol width
STATE_W, 3, state register width
OUT_W, 8, output symbol width
NUM_STATES, 6, legal states are 0..NUM_STATES-1 (NUM_STATES <= 2**STATE_W)
RESET_STATE, 0, state entered on reset and on restart

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  STATE_W+IN_W  entry address = {state, in}
cfg_valid  in  1  entry-specified bit written with the entry (0 = erase entry)
cfg_next  in  STATE_W  next-state field
cfg_out  in  OUT_W  output field
restart  in  1  return to RESET_STATE without touching the table
in_valid  in  1  qualifies in; one transition per qualified cycle
in  in  IN_W  input symbol
out  out  OUT_W  registered Mealy output
out_valid  out  1  out/state updated this cycle
state  out  STATE_W  current state
miss  out  1  last qualified step hit an unspecified entry
err  out  1  sticky: illegal state or illegal config target seen

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset values while rst_n=0 at a clk edge: state=RESET_STATE, out=0, out_valid=0, miss=0, err=0. All table valid bits are cleared. Next/out fields need no reset.
- Table: 2**(STATE_W+IN_W) entries of {valid, next, out}.
- Write occurs when cfg_we=1. If cfg_addr's state field is >= NUM_STATES, or cfg_next >= NUM_STATES with cfg_valid=1: the write is dropped and err is set.
- Step: when in_valid=1, entry E = table[{state, in}] is read combinationally. Results register at the next edge (latency 1 cycle, same as the fixed FSMs).
  - E.valid=1: state<=E.next, out<=E.out, miss<=0.
  - E.valid=0: state held, out<=0, miss<=1.
  - out_valid<=1 in both cases.
- in_valid=0: out_valid<=0. out, state and miss hold their values.
- Cycle with no step: out is not cleared. The fixed FSMs cleared it every clock; this block does not.
- Simultaneous cfg write and step to the same address: the step uses the old entry (read-before-write). The new entry applies from the next cycle.
- restart=1: state<=RESET_STATE, out<=0, out_valid<=0, miss<=0. Restart has priority over a step in the same cycle. A cfg write in the same cycle still occurs. err is unaffected.
- Priority: rst_n > restart > step.
- Illegal state guard: if state >= NUM_STATES at a step, state<=RESET_STATE, out<=0, err<=1. Reachable only through upsets.
- Width rules: in is used at full width, with no implicit truncation. Symbols not loaded into the table behave as misses.
- Reset mid-run: any in-flight step is discarded and the table is emptied. Software must reload the table.

Decomposition:
- Package stt_pkg holds:
  - default parameter constants;
  - function stt_addr(state, in) returning the packed address;
  - localparam-width helpers for the entry layout {valid, next, out}.
- Natural sub-module: stt_table. It contains the storage array, the valid-bit vector with synchronous clear, the write port with legality check, and an async read port with read-before-write semantics.
- Top level holds the state/out/miss/err registers and the priority logic.

Test Plan:
- Load (s0, in1)->(s2, out 1) and (s2, in2)->(s1, out 15). Apply in=1 then in=2 with in_valid=1 -> out 1 then 15; state 2 then 1; out_valid=1 both cycles.
- From s1, step with unloaded in=11 -> state stays 1, out=0, miss=1. Next step with a loaded entry -> miss returns to 0.
- Hold in_valid=0 for 3 cycles after out=7 -> out stays 7, out_valid=0, state unchanged.
- Same cycle: write (s0, in0)->(s3, out 9) and step s0 in0 while old entry is (s1, out 0) -> state 1, out 0. Repeat after restart -> state 3, out 9.
- Write cfg_addr with state field 6, and separately cfg_next=7 with cfg_valid=1 (NUM_STATES=6) -> no table change, err=1 and sticky through restart. err clears only on rst_n=0.
- Mid-sequence rst_n=0 for one cycle -> state 0, out 0, out_valid 0; a step on any former entry -> miss=1.
